// File: rtl/led_accum_ctrl_pkg.sv
// Shared types and defaults for the LED accumulator controller:
// debounce state encoding, default sizes and the counter width helper.
package led_accum_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } deb_state_t;

    localparam int unsigned WIDTH_DEFAULT           = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    // A one-cycle debounce still needs a 1-bit counter to keep widths legal.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned DEBOUNCE_CNT_W = cnt_width(DEBOUNCE_CYCLES_DEFAULT);

endpackage

// File: rtl/led_accum_ctrl_if.sv
// CPU-side write port from the PIO bridge into the accumulator register.
interface led_accum_ctrl_if
    import led_accum_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic             cpu_wr_valid;
    logic [WIDTH-1:0] cpu_wr_data;
    logic             cpu_wr_ready;

    modport master (
        output cpu_wr_valid,
        output cpu_wr_data,
        input  cpu_wr_ready
    );

    modport slave (
        input  cpu_wr_valid,
        input  cpu_wr_data,
        output cpu_wr_ready
    );

endinterface

// File: rtl/led_accum_ctrl_key_debounce.sv
// Raw active-low key -> 2-flop synchronizer -> debounce FSM.
// Emits a single-cycle press pulse once a press has been stable long enough.
module key_debounce
    import led_accum_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_press_pulse
);

    localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_last;

    // Synchronizers reset to the released level so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            RELEASED: begin
                if (!r_sync2) begin
                    w_state_next = PRESS_CHK;
                    w_cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (r_sync2) begin
                    w_state_next = RELEASED;
                end else if (w_cnt_last) begin
                    w_state_next = HELD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (r_sync2) begin
                    w_state_next = RELEASE_CHK;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_CHK: begin
                if (!r_sync2) begin
                    w_state_next = HELD;
                end else if (w_cnt_last) begin
                    w_state_next = RELEASED;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = RELEASED;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_press_pulse = (r_state == PRESS_CHK) && !r_sync2 && w_cnt_last;
    end

endmodule

// File: rtl/led_accum_ctrl.sv
// Arbitrates the LED accumulator between clear key, CPU writes and the
// accumulate key (fixed priority in that order), with a one-deep pending slot.
module led_accum_ctrl
    import led_accum_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             accumulate_n,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] sw,
    led_accum_ctrl_if.slave  cpu,
    output logic [WIDTH-1:0] led,
    output logic             carry
);

    logic             w_acc_pulse;
    logic             w_clr_pulse;
    logic             w_cpu_xfer;
    logic             w_acc_req;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] r_led;
    logic             r_carry;
    logic             r_acc_pending;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_acc_key (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_key_n       (accumulate_n),
        .o_press_pulse (w_acc_pulse)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_key (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_key_n       (clear_n),
        .o_press_pulse (w_clr_pulse)
    );

    assign cpu.cpu_wr_ready = ~w_clr_pulse;
    assign w_cpu_xfer       = cpu.cpu_wr_valid & ~w_clr_pulse;
    assign w_acc_req        = w_acc_pulse | r_acc_pending;
    assign w_sum            = {1'b0, r_led} + {1'b0, sw};

    // A blocked accumulate (new or already pending) parks in the single slot;
    // extra pulses while it is occupied simply collapse into it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_led         <= '0;
            r_carry       <= 1'b0;
            r_acc_pending <= 1'b0;
        end else if (w_clr_pulse) begin
            r_led         <= '0;
            r_carry       <= 1'b0;
            r_acc_pending <= 1'b0;
        end else if (w_cpu_xfer) begin
            r_led         <= cpu.cpu_wr_data;
            r_carry       <= 1'b0;
            r_acc_pending <= w_acc_req;
        end else if (w_acc_req) begin
            r_led         <= w_sum[WIDTH-1:0];
            r_carry       <= r_carry | w_sum[WIDTH];
            r_acc_pending <= 1'b0;
        end
    end

    assign led   = r_led;
    assign carry = r_carry;

endmodule

// File: tb/tb_led_accum_ctrl.sv
// Self-checking bench for led_accum_ctrl with a short debounce window.
module tb_led_accum_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         accumulate_n;
    logic         clear_n;
    logic [W-1:0] sw;
    logic [W-1:0] led;
    logic         carry;

    led_accum_ctrl_if #(.WIDTH(W)) cpu_if ();

    led_accum_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .accumulate_n (accumulate_n),
        .clear_n      (clear_n),
        .sw           (sw),
        .cpu          (cpu_if),
        .led          (led),
        .carry        (carry)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the LED register and carry should hold.
    int m_led   = 0;
    int m_carry = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_led"}, 32'(led), 32'(m_led));
        chk({tag, "_carry"}, 32'(carry), 32'(m_carry));
    endtask

    function automatic void model_acc(input int operand);
        int s;
        s = m_led + operand;
        if (s > 255) m_carry = 1;
        m_led = s % 256;
    endfunction

    task automatic press_acc(input logic [W-1:0] v);
        sw = v;
        accumulate_n = 1'b0;
        tick(10);
        accumulate_n = 1'b1;
        tick(10);
        model_acc(int'(v));
    endtask

    task automatic press_clr();
        clear_n = 1'b0;
        tick(10);
        clear_n = 1'b1;
        tick(10);
        m_led = 0;
        m_carry = 0;
    endtask

    task automatic cpu_write(input logic [W-1:0] d);
        cpu_if.cpu_wr_valid = 1'b1;
        cpu_if.cpu_wr_data  = d;
        tick(1);
        cpu_if.cpu_wr_valid = 1'b0;
        m_led = int'(d);
        m_carry = 0;
    endtask

    task automatic bounce(input bit on_clear, input logic [W-1:0] v);
        sw = v;
        for (int i = 0; i < 5; i++) begin
            if (on_clear) clear_n = 1'b0; else accumulate_n = 1'b0;
            tick(2);
            if (on_clear) clear_n = 1'b1; else accumulate_n = 1'b1;
            tick(2);
        end
        tick(10);
    endtask

    initial begin
        reset_n             = 1'b0;
        accumulate_n        = 1'b1;
        clear_n             = 1'b1;
        sw                  = '0;
        cpu_if.cpu_wr_valid = 1'b0;
        cpu_if.cpu_wr_data  = '0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        chk_state("reset");
        chk("reset_ready", 32'(cpu_if.cpu_wr_ready), 32'd1);

        // Held key: one update per press.
        press_acc(8'h05);
        chk_state("press1");
        press_acc(8'h05);
        chk_state("press2");

        bounce(1'b0, 8'h33);
        chk_state("bounce_acc");

        // Overflow and sticky carry.
        cpu_write(8'hF0);
        chk_state("cpu_f0");
        press_acc(8'h20);
        chk_state("ovf");
        press_acc(8'h01);
        chk_state("ovf_sticky");

        // CPU write in the accumulate pulse cycle (raw fall + 2 sync + DC edges).
        sw = 8'h01;
        accumulate_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cpu_if.cpu_wr_valid = 1'b1;
        cpu_if.cpu_wr_data  = 8'h40;
        tick(1);
        cpu_if.cpu_wr_valid = 1'b0;
        m_led = 'h40;
        m_carry = 0;
        chk_state("coll_write");
        tick(1);
        model_acc(1);
        chk_state("coll_pending");
        accumulate_n = 1'b1;
        tick(10);
        chk_state("coll_settle");

        // Clear pulse stalls a concurrent CPU write for exactly that cycle.
        clear_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cpu_if.cpu_wr_valid = 1'b1;
        cpu_if.cpu_wr_data  = 8'h5A;
        chk("clr_ready", 32'(cpu_if.cpu_wr_ready), 32'd0);
        tick(1);
        m_led = 0;
        m_carry = 0;
        chk_state("clr_coll");
        chk("clr_ready_after", 32'(cpu_if.cpu_wr_ready), 32'd1);
        tick(1);
        cpu_if.cpu_wr_valid = 1'b0;
        m_led = 'h5A;
        chk_state("clr_write_done");
        clear_n = 1'b1;
        tick(10);

        // Reset in the middle of a press check.
        accumulate_n = 1'b0;
        sw = 8'h07;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        accumulate_n = 1'b1;
        tick(1);
        reset_n = 1'b1;
        m_led = 0;
        m_carry = 0;
        tick(1);
        chk_state("rst_mid_press");
        tick(15);
        chk_state("rst_mid_press_after");

        // Reset with an accumulate pending behind continuous CPU writes.
        cpu_write(8'h10);
        sw = 8'h03;
        cpu_if.cpu_wr_valid = 1'b1;
        cpu_if.cpu_wr_data  = 8'h22;
        accumulate_n = 1'b0;
        tick(12);
        accumulate_n = 1'b1;
        tick(10);
        reset_n = 1'b0;
        tick(1);
        cpu_if.cpu_wr_valid = 1'b0;
        tick(1);
        reset_n = 1'b1;
        m_led = 0;
        m_carry = 0;
        tick(1);
        chk_state("rst_pending");
        tick(15);
        chk_state("rst_pending_after");

        // Randomized operation mix against the reference model.
        for (int i = 0; i < 30; i++) begin
            int unsigned op;
            logic [W-1:0] v;
            op = $urandom_range(0, 5);
            v  = W'($urandom_range(0, 255));
            case (op)
                0, 1: press_acc(v);
                2:    press_clr();
                3:    cpu_write(v);
                4:    bounce(1'b0, v);
                default: bounce(1'b1, v);
            endcase
            chk_state($sformatf("rnd%0d_op%0d", i, op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
